// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   inst_addr_t / inst_t : instruction address and instruction word buses
//   ZERO_WORD            : all-zero word, used as the NOP bubble
//   PC_STEP_DEF          : default byte step between sequential fetches
//   if_state_e           : fetch FSM states (BOOT, WAIT, HOLD)
// ---------------------------------------------------------------------------
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_t       ZERO_WORD   = '0;
  localparam int unsigned PC_STEP_DEF = 4;

  // BOOT : out of reset, no request issued yet
  // WAIT : a memory request is outstanding
  // HOLD : a fetched word is parked in the skid buffer, no request out
  typedef enum logic [1:0] {
    IF_BOOT = 2'd0,
    IF_WAIT = 2'd1,
    IF_HOLD = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_fetch_skid_buf.sv
// ---------------------------------------------------------------------------
// if_fetch_skid_buf
// One-entry pc+instruction holding register. Catches a fetched word that
// arrives while the pipeline is stalled so it can be replayed later.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : capture i_pc / i_inst, mark full
//   i_clear        : drop the entry (wins over i_load)
//   i_pc, i_inst   : word to capture
//   o_full         : entry holds a valid word
//   o_pc, o_inst   : stored word
// ---------------------------------------------------------------------------
module if_fetch_skid_buf
  import if_fetch_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_clear,
  input  inst_addr_t i_pc,
  input  inst_t      i_inst,
  output logic       o_full,
  output inst_addr_t o_pc,
  output inst_t      o_inst
);

  logic       r_full;
  inst_addr_t r_pc;
  inst_t      r_inst;

  // A clear comes from a branch redirect, so it must discard the entry even
  // if a load is requested in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
      r_pc   <= '0;
      r_inst <= ZERO_WORD;
    end else if (i_clear) begin
      r_full <= 1'b0;
      r_pc   <= '0;
      r_inst <= ZERO_WORD;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_pc   <= i_pc;
      r_inst <= i_inst;
    end
  end

  assign o_full = r_full;
  assign o_pc   = r_pc;
  assign o_inst = r_inst;

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage. Owns the PC, fetches words from instruction
// memory over a req/ack handshake and presents pc/instruction to IF/ID.
// Honours the IF/ID stall and branch-redirect controls; bubbles are zero.
// Parameters:
//   RESET_PC : first fetch address after reset
//   PC_STEP  : byte increment between sequential fetches
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_stall               : IF/ID is not loading this cycle
//   i_branch              : redirect request (highest priority)
//   i_branch_target       : redirect PC, low two bits ignored
//   o_imem_req/o_imem_addr: registered fetch request and address
//   i_imem_ack/i_imem_rdata: one-cycle ack with data in the same cycle
//   o_if_pc/o_if_inst/o_if_valid : word toward IF/ID
// Optional build macro IF_PERF_CNT_EN adds:
//   o_fetch_cnt : count of accepted (non-stale) fetches
//   o_stall_cnt : count of cycles stalled while holding a valid word
// ---------------------------------------------------------------------------
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t  RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_stall,
  input  logic       i_branch,
  input  inst_addr_t i_branch_target,
  output logic       o_imem_req,
  output inst_addr_t o_imem_addr,
  input  logic       i_imem_ack,
  input  inst_t      i_imem_rdata,
  output inst_addr_t o_if_pc,
  output inst_t      o_if_inst,
  output logic       o_if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt
`endif
);

  if_state_e  r_state,     w_state_nxt;
  inst_addr_t r_pc,        w_pc_nxt;
  logic       r_imem_req,  w_imem_req_nxt;
  inst_addr_t r_imem_addr, w_imem_addr_nxt;
  logic       r_stale,     w_stale_nxt;
  inst_addr_t r_if_pc,     w_if_pc_nxt;
  inst_t      r_if_inst,   w_if_inst_nxt;
  logic       r_if_valid,  w_if_valid_nxt;

  logic       w_skid_load;
  logic       w_skid_clear;
  logic       w_skid_full;
  inst_addr_t w_skid_pc;
  inst_t      w_skid_inst;

  inst_addr_t w_target;
  inst_addr_t w_seq_addr;

  assign w_target   = i_branch_target & ~inst_addr_t'(3);
  assign w_seq_addr = r_imem_addr + inst_addr_t'(PC_STEP);

  if_fetch_skid_buf u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_pc    (r_imem_addr),
    .i_inst  (i_imem_rdata),
    .o_full  (w_skid_full),
    .o_pc    (w_skid_pc),
    .o_inst  (w_skid_inst)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IF_BOOT;
    else          r_state <= w_state_nxt;
  end

  // Datapath registers: PC, request, stale flag and IF/ID-facing outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc        <= RESET_PC;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
      r_stale     <= 1'b0;
      r_if_pc     <= ZERO_WORD;
      r_if_inst   <= ZERO_WORD;
      r_if_valid  <= 1'b0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_imem_req  <= w_imem_req_nxt;
      r_imem_addr <= w_imem_addr_nxt;
      r_stale     <= w_stale_nxt;
      r_if_pc     <= w_if_pc_nxt;
      r_if_inst   <= w_if_inst_nxt;
      r_if_valid  <= w_if_valid_nxt;
    end
  end

  // Next-state logic. A request in flight cannot be aborted, so a redirect
  // that arrives without an ack only marks the pending reply as stale; the
  // reply is dropped on arrival and the redirected PC is fetched instead.
  // The PC register always holds the address of the next word to request.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_imem_req_nxt  = r_imem_req;
    w_imem_addr_nxt = r_imem_addr;
    w_stale_nxt     = r_stale;
    w_skid_load     = 1'b0;
    w_skid_clear    = 1'b0;
    w_if_pc_nxt     = r_if_pc;
    w_if_inst_nxt   = r_if_inst;
    w_if_valid_nxt  = r_if_valid;

    // Outputs hold while stalled and turn into a bubble otherwise, unless
    // a word is delivered below.
    if (!i_stall) begin
      w_if_inst_nxt  = ZERO_WORD;
      w_if_valid_nxt = 1'b0;
    end

    if (i_branch) begin
      w_pc_nxt       = w_target;
      w_if_inst_nxt  = ZERO_WORD;
      w_if_valid_nxt = 1'b0;
      w_skid_clear   = 1'b1;
      case (r_state)
        IF_WAIT: begin
          if (i_imem_ack) begin
            w_imem_addr_nxt = w_target;
            w_stale_nxt     = 1'b0;
          end else begin
            w_stale_nxt     = 1'b1;
          end
        end
        default: begin
          w_state_nxt     = IF_WAIT;
          w_imem_req_nxt  = 1'b1;
          w_imem_addr_nxt = w_target;
        end
      endcase
    end else begin
      case (r_state)
        IF_BOOT: begin
          w_state_nxt     = IF_WAIT;
          w_imem_req_nxt  = 1'b1;
          w_imem_addr_nxt = r_pc;
        end
        IF_WAIT: begin
          if (i_imem_ack) begin
            if (r_stale) begin
              w_stale_nxt     = 1'b0;
              w_imem_addr_nxt = r_pc;
            end else if (!i_stall) begin
              w_if_pc_nxt     = r_imem_addr;
              w_if_inst_nxt   = i_imem_rdata;
              w_if_valid_nxt  = 1'b1;
              w_pc_nxt        = w_seq_addr;
              w_imem_addr_nxt = w_seq_addr;
            end else begin
              // Park the word and stop fetching until the stall clears.
              w_skid_load    = 1'b1;
              w_imem_req_nxt = 1'b0;
              w_pc_nxt       = w_seq_addr;
              w_state_nxt    = IF_HOLD;
            end
          end
        end
        IF_HOLD: begin
          if (!i_stall && w_skid_full) begin
            w_if_pc_nxt     = w_skid_pc;
            w_if_inst_nxt   = w_skid_inst;
            w_if_valid_nxt  = 1'b1;
            w_skid_clear    = 1'b1;
            w_imem_req_nxt  = 1'b1;
            w_imem_addr_nxt = r_pc;
            w_state_nxt     = IF_WAIT;
          end
        end
        default: begin
          w_state_nxt = IF_BOOT;
        end
      endcase
    end
  end

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_imem_addr;
  assign o_if_pc     = r_if_pc;
  assign o_if_inst   = r_if_inst;
  assign o_if_valid  = r_if_valid;

`ifdef IF_PERF_CNT_EN
  logic        w_fetch_accept;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  assign w_fetch_accept = !i_branch && (r_state == IF_WAIT) && i_imem_ack && !r_stale;

  // Free-running wrap-around event counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fetch_accept)        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (i_stall && r_if_valid) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
